// File: rtl/anabellek_denetleyici.sv
// Main-memory controller: turns single 128-bit block read/write requests from a
// cache controller into four 32-bit beats on a word-wide memory port.
// Optional build macro ANABELLEK_ZAMAN_ASIMI_EN adds a per-beat timeout
// (ZAMAN_ASIMI_CEVRIM cycles) that ends the block early with hata_o set.
module anabellek_denetleyici #(
    parameter int unsigned ZAMAN_ASIMI_CEVRIM = 1024
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         istek_i,
    input  logic [31:0]  adres_i,
    input  logic         oku_i,
    input  logic         yaz_i,
    input  logic [127:0] yazilacak_obek_i,
    output logic         musait_o,
    output logic         hazir_o,
    output logic [127:0] okunan_obek_o,
    output logic         hata_o,
    output logic         bellek_istek_o,
    output logic         bellek_yaz_o,
    output logic [31:0]  bellek_adres_o,
    output logic [31:0]  bellek_veri_o,
    input  logic         bellek_gecerli_i,
    input  logic [31:0]  bellek_veri_i
);

    localparam int unsigned KELIME_W   = 32;
    localparam int unsigned KELIME_SAY = 4;
    localparam int unsigned SAYAC_W    = 2;
    localparam int unsigned TABAN_W    = 28;

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        OKU   = 2'd1,
        YAZ   = 2'd2,
        TAMAM = 2'd3
    } durum_t;

    durum_t               durum_r;
    logic [SAYAC_W-1:0]   sayac_r;
    logic [TABAN_W-1:0]   taban_r;
    logic [KELIME_W-1:0]  yaz_tampon_r [KELIME_SAY];
    logic [KELIME_W-1:0]  oku_tampon_r [KELIME_SAY];

    logic calisiyor_c;
    logic kabul_c;
    logic son_vurus_c;
    logic zaman_asimi_c;

    // The low nibble of the request address is a byte offset inside the block.
    logic unused_adres_c;
    assign unused_adres_c = ^adres_i[3:0];

    // Request handshake and beat-phase decode.
    assign calisiyor_c = (durum_r == OKU) || (durum_r == YAZ);
    assign kabul_c     = (durum_r == BOSTA) && istek_i && (oku_i || yaz_i);
    assign son_vurus_c = bellek_gecerli_i && (sayac_r == SAYAC_W'(KELIME_SAY - 1));

`ifdef ANABELLEK_ZAMAN_ASIMI_EN
    localparam int unsigned BEKLE_W = $clog2(ZAMAN_ASIMI_CEVRIM + 1);

    logic [BEKLE_W-1:0] bekle_r;
    logic               hata_r;

    assign zaman_asimi_c = calisiyor_c && !bellek_gecerli_i &&
                           (bekle_r == BEKLE_W'(ZAMAN_ASIMI_CEVRIM - 1));
    assign hata_o        = hata_r;

    // Per-beat wait counter and sticky timeout flag (cleared by the next accepted request).
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bekle_r <= '0;
            hata_r  <= 1'b0;
        end else if (kabul_c) begin
            bekle_r <= '0;
            hata_r  <= 1'b0;
        end else if (calisiyor_c) begin
            if (bellek_gecerli_i || zaman_asimi_c) begin
                bekle_r <= '0;
            end else begin
                bekle_r <= bekle_r + BEKLE_W'(1);
            end
            if (zaman_asimi_c) begin
                hata_r <= 1'b1;
            end
        end
    end
`else
    // Without the timeout the controller waits for the memory indefinitely.
    logic unused_zaman_c;
    assign unused_zaman_c = (ZAMAN_ASIMI_CEVRIM == 32'd0);
    assign zaman_asimi_c  = 1'b0;
    assign hata_o         = 1'b0;
`endif

    // Controller FSM with beat counter, latched base address and block buffers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            durum_r <= BOSTA;
            sayac_r <= '0;
            taban_r <= '0;
            for (int unsigned k = 0; k < KELIME_SAY; k++) begin
                yaz_tampon_r[k] <= '0;
                oku_tampon_r[k] <= '0;
            end
        end else begin
            case (durum_r)
                BOSTA: begin
                    if (kabul_c) begin
                        taban_r <= adres_i[31:4];
                        sayac_r <= '0;
                        for (int unsigned k = 0; k < KELIME_SAY; k++) begin
                            yaz_tampon_r[k] <= yazilacak_obek_i[KELIME_W*k +: KELIME_W];
                        end
`ifdef ANABELLEK_ZAMAN_ASIMI_EN
                        // A timed-out read must show zeros for the words it never got.
                        if (!yaz_i) begin
                            for (int unsigned k = 0; k < KELIME_SAY; k++) begin
                                oku_tampon_r[k] <= '0;
                            end
                        end
`endif
                        durum_r <= yaz_i ? YAZ : OKU;
                    end
                end
                OKU, YAZ: begin
                    if (bellek_gecerli_i) begin
                        if (durum_r == OKU) begin
                            oku_tampon_r[sayac_r] <= bellek_veri_i;
                        end
                        sayac_r <= sayac_r + SAYAC_W'(1);
                        if (son_vurus_c) begin
                            durum_r <= TAMAM;
                        end
                    end else if (zaman_asimi_c) begin
                        sayac_r <= '0;
                        durum_r <= TAMAM;
                    end
                end
                TAMAM: begin
                    durum_r <= BOSTA;
                end
                default: begin
                    durum_r <= BOSTA;
                end
            endcase
        end
    end

    // Output decode straight from the state and buffer registers.
    assign musait_o       = (durum_r == BOSTA);
    assign hazir_o        = (durum_r == TAMAM);
    assign bellek_istek_o = calisiyor_c;
    assign bellek_yaz_o   = (durum_r == YAZ);
    assign bellek_adres_o = calisiyor_c ? {taban_r, sayac_r, 2'b00} : '0;
    assign bellek_veri_o  = (durum_r == YAZ) ? yaz_tampon_r[sayac_r] : '0;
    assign okunan_obek_o  = {oku_tampon_r[3], oku_tampon_r[2], oku_tampon_r[1], oku_tampon_r[0]};

endmodule

// File: tb/tb_anabellek_denetleyici.sv
// Directed bench for anabellek_denetleyici with a small word-memory responder.
module tb_anabellek_denetleyici;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         istek_i = 1'b0;
    logic [31:0]  adres_i = '0;
    logic         oku_i = 1'b0;
    logic         yaz_i = 1'b0;
    logic [127:0] yazilacak_obek_i = '0;
    logic         musait_o;
    logic         hazir_o;
    logic [127:0] okunan_obek_o;
    logic         hata_o;
    logic         bellek_istek_o;
    logic         bellek_yaz_o;
    logic [31:0]  bellek_adres_o;
    logic [31:0]  bellek_veri_o;
    logic         bellek_gecerli_i = 1'b0;
    logic [31:0]  bellek_veri_i = '0;

    anabellek_denetleyici #(.ZAMAN_ASIMI_CEVRIM(8)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .istek_i          (istek_i),
        .adres_i          (adres_i),
        .oku_i            (oku_i),
        .yaz_i            (yaz_i),
        .yazilacak_obek_i (yazilacak_obek_i),
        .musait_o         (musait_o),
        .hazir_o          (hazir_o),
        .okunan_obek_o    (okunan_obek_o),
        .hata_o           (hata_o),
        .bellek_istek_o   (bellek_istek_o),
        .bellek_yaz_o     (bellek_yaz_o),
        .bellek_adres_o   (bellek_adres_o),
        .bellek_veri_o    (bellek_veri_o),
        .bellek_gecerli_i (bellek_gecerli_i),
        .bellek_veri_i    (bellek_veri_i)
    );

    always #5 clk_i = ~clk_i;

    int toplam = 0;
    int bad = 0;
    int cyc = 0;

    // Memory responder state and beat log.
    int          bekleme = 0;
    int          bekle_say = 0;
    int          izin = 1000000;
    logic [31:0] veri_tabani = '0;
    logic [31:0] log_adres [$];
    logic        log_yaz [$];
    logic [31:0] log_veri [$];
    int          hazir_say = 0;
    int          hazir_cyc = 0;

    always @(posedge clk_i) cyc++;

    // Memory model: answers each beat after 'bekleme' wait cycles, goes silent when izin runs out.
    always @(negedge clk_i) begin
        if (bellek_istek_o && izin != 0) begin
            if (bekle_say == bekleme) begin
                bellek_gecerli_i = 1'b1;
                bellek_veri_i    = veri_tabani + 32'(bellek_adres_o[3:2]);
                log_adres.push_back(bellek_adres_o);
                log_yaz.push_back(bellek_yaz_o);
                log_veri.push_back(bellek_veri_o);
                bekle_say = 0;
                izin--;
            end else begin
                bellek_gecerli_i = 1'b0;
                bekle_say++;
            end
        end else begin
            bellek_gecerli_i = 1'b0;
            bekle_say = 0;
        end
        if (hazir_o) begin
            hazir_say++;
            hazir_cyc = cyc;
        end
    end

    task automatic kontrol(input string etiket, input logic [127:0] gozlenen, input logic [127:0] beklenen);
        toplam++;
        if (gozlenen !== beklenen) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", etiket, gozlenen, beklenen);
        end
    endtask

    task automatic saat(input int n);
        repeat (n) begin
            @(negedge clk_i);
            #1;
        end
    endtask

    task automatic log_temizle();
        log_adres.delete();
        log_yaz.delete();
        log_veri.delete();
    endtask

    // Presents one request for a single cycle, then scrambles the inputs.
    task automatic istek_gonder(input logic [31:0] a, input logic o, input logic y,
                                input logic [127:0] b, output int t0);
        istek_i = 1'b1;
        adres_i = a;
        oku_i = o;
        yaz_i = y;
        yazilacak_obek_i = b;
        t0 = cyc;
        saat(1);
        istek_i = 1'b0;
        oku_i = 1'b0;
        yaz_i = 1'b0;
        adres_i = 32'hDEAD_BEEF;
        yazilacak_obek_i = {4{32'hBAD0_BAD0}};
    endtask

    task automatic bitmesini_bekle(input string etiket, input int h0);
        int n;
        n = 0;
        while (hazir_say == h0 && n < 200) begin
            saat(1);
            n++;
        end
        kontrol(etiket, 128'(hazir_say - h0), 128'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int h0;
        int mus_ihlal;
        logic [127:0] onceki;

        // Reset values.
        saat(2);
        kontrol("rst_musait", 128'(musait_o), 128'd1);
        kontrol("rst_hazir", 128'(hazir_o), 128'd0);
        kontrol("rst_hata", 128'(hata_o), 128'd0);
        kontrol("rst_okunan", okunan_obek_o, 128'd0);
        kontrol("rst_bellek", {bellek_istek_o, bellek_yaz_o, bellek_adres_o, bellek_veri_o}, 128'd0);
        rst_i = 1'b1;
        saat(1);

        // Zero-wait read at 0x1234.
        log_temizle();
        bekleme = 0;
        veri_tabani = 32'hA0;
        h0 = hazir_say;
        istek_gonder(32'h0000_1234, 1'b1, 1'b0, '0, t0);
        kontrol("oku_musait_mesgul", 128'(musait_o), 128'd0);
        bitmesini_bekle("oku_tamam", h0);
        kontrol("oku_hazir", 128'(hazir_o), 128'd1);
        kontrol("oku_gecikme", 128'(hazir_cyc - t0), 128'd5);
        kontrol("oku_vurus_say", 128'(log_adres.size()), 128'd4);
        for (int i = 0; i < log_adres.size(); i++) begin
            kontrol($sformatf("oku_adres%0d", i), 128'(log_adres[i]), 128'(32'h1230 + 32'(4 * i)));
            kontrol($sformatf("oku_yaz%0d", i), 128'(log_yaz[i]), 128'd0);
        end
        kontrol("oku_obek", okunan_obek_o, 128'h000000A3_000000A2_000000A1_000000A0);
        kontrol("oku_hata", 128'(hata_o), 128'd0);
        saat(1);
        kontrol("oku_sonra_musait", 128'(musait_o), 128'd1);
        kontrol("oku_tek_darbe", 128'(hazir_o), 128'd0);

        // Write at 0x40.
        log_temizle();
        h0 = hazir_say;
        istek_gonder(32'h0000_0040, 1'b0, 1'b1, 128'h44444444_33333333_22222222_11111111, t0);
        bitmesini_bekle("yaz_tamam", h0);
        kontrol("yaz_vurus_say", 128'(log_adres.size()), 128'd4);
        for (int i = 0; i < log_adres.size(); i++) begin
            kontrol($sformatf("yaz_adres%0d", i), 128'(log_adres[i]), 128'(32'h40 + 32'(4 * i)));
            kontrol($sformatf("yaz_bit%0d", i), 128'(log_yaz[i]), 128'd1);
            kontrol($sformatf("yaz_veri%0d", i), 128'(log_veri[i]), 128'(32'h11111111 * 32'(i + 1)));
        end
        kontrol("yaz_okunan_ayni", okunan_obek_o, 128'h000000A3_000000A2_000000A1_000000A0);
        saat(3);
        kontrol("yaz_darbe_say", 128'(hazir_say - h0), 128'd1);

        // Two wait cycles per beat, with an ignored request at T+3.
        log_temizle();
        bekleme = 2;
        veri_tabani = 32'hB0;
        h0 = hazir_say;
        mus_ihlal = 0;
        istek_gonder(32'h0000_2000, 1'b1, 1'b0, '0, t0);
        for (int k = 1; k <= 13; k++) begin
            if (musait_o) mus_ihlal++;
            if (k == 3) begin
                istek_i = 1'b1;
                yaz_i = 1'b1;
                adres_i = 32'h0000_5000;
            end
            if (k == 4) begin
                istek_i = 1'b0;
                yaz_i = 1'b0;
            end
            if (k == 13) kontrol("bekle_hazir_t13", 128'(hazir_o), 128'd1);
            if (k < 13) saat(1);
        end
        kontrol("bekle_musait_dusuk", 128'(mus_ihlal), 128'd0);
        kontrol("bekle_gecikme", 128'(hazir_cyc - t0), 128'd13);
        kontrol("bekle_obek", okunan_obek_o, 128'h000000B3_000000B2_000000B1_000000B0);
        saat(1);
        kontrol("bekle_sonra_musait", 128'(musait_o), 128'd1);
        saat(4);
        kontrol("bekle_istek_yok_sayildi", 128'(log_adres.size()), 128'd4);
        kontrol("bekle_darbe_say", 128'(hazir_say - h0), 128'd1);

        // Reset during beat 2, then a normal read.
        log_temizle();
        bekleme = 0;
        veri_tabani = 32'hE0;
        h0 = hazir_say;
        istek_gonder(32'h0000_3000, 1'b1, 1'b0, '0, t0);
        saat(2);
        kontrol("rsta_sayac_iki", 128'(bellek_adres_o), 128'h3008);
        rst_i = 1'b0;
        #1;
        kontrol("rsta_istek", 128'(bellek_istek_o), 128'd0);
        kontrol("rsta_musait", 128'(musait_o), 128'd1);
        kontrol("rsta_okunan", okunan_obek_o, 128'd0);
        kontrol("rsta_adres", 128'(bellek_adres_o), 128'd0);
        saat(1);
        rst_i = 1'b1;
        saat(3);
        kontrol("rsta_hazir_yok", 128'(hazir_say - h0), 128'd0);
        veri_tabani = 32'hC0;
        istek_gonder(32'h0000_1234, 1'b1, 1'b0, '0, t0);
        bitmesini_bekle("rsta_sonra_tamam", h0);
        kontrol("rsta_sonra_obek", okunan_obek_o, 128'h000000C3_000000C2_000000C1_000000C0);
        saat(1);

        // Both read and write set: write wins.
        log_temizle();
        h0 = hazir_say;
        istek_gonder(32'h0000_0080, 1'b1, 1'b1, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, t0);
        bitmesini_bekle("ikisi_tamam", h0);
        kontrol("ikisi_vurus_say", 128'(log_adres.size()), 128'd4);
        if (log_adres.size() == 4) begin
            kontrol("ikisi_yaz0", 128'(log_yaz[0]), 128'd1);
            kontrol("ikisi_yaz3", 128'(log_yaz[3]), 128'd1);
            kontrol("ikisi_veri0", 128'(log_veri[0]), 128'hAAAAAAAA);
            kontrol("ikisi_veri3", 128'(log_veri[3]), 128'hDDDDDDDD);
            kontrol("ikisi_adres3", 128'(log_adres[3]), 128'h8C);
        end
        kontrol("ikisi_okunan_ayni", okunan_obek_o, 128'h000000C3_000000C2_000000C1_000000C0);
        saat(1);

        // Strobe with neither read nor write: nothing happens.
        log_temizle();
        h0 = hazir_say;
        istek_gonder(32'h0000_0100, 1'b0, 1'b0, '0, t0);
        kontrol("bos_musait", 128'(musait_o), 128'd1);
        kontrol("bos_bellek_istek", 128'(bellek_istek_o), 128'd0);
        saat(6);
        kontrol("bos_vurus_yok", 128'(log_adres.size()), 128'd0);
        kontrol("bos_hazir_yok", 128'(hazir_say - h0), 128'd0);

`ifdef ANABELLEK_ZAMAN_ASIMI_EN
        // Memory goes silent after the first beat.
        log_temizle();
        izin = 1;
        veri_tabani = 32'hD0;
        h0 = hazir_say;
        istek_gonder(32'h0000_0100, 1'b1, 1'b0, '0, t0);
        bitmesini_bekle("zaman_tamam", h0);
        kontrol("zaman_hazir", 128'(hazir_o), 128'd1);
        kontrol("zaman_hata", 128'(hata_o), 128'd1);
        kontrol("zaman_obek", okunan_obek_o, 128'h00000000_00000000_00000000_000000D0);
        saat(1);
        kontrol("zaman_istek_dustu", 128'(bellek_istek_o), 128'd0);
        izin = 1000000;
        h0 = hazir_say;
        istek_gonder(32'h0000_0040, 1'b0, 1'b1, 128'h1, t0);
        kontrol("zaman_hata_temiz", 128'(hata_o), 128'd0);
        bitmesini_bekle("zaman_sonra_tamam", h0);
        kontrol("zaman_sonra_hata", 128'(hata_o), 128'd0);
`endif

        saat(2);
        $display("test done: total=%0d bad=%0d", toplam, bad);
        $finish;
    end

endmodule
